fp16_vec_reduce: RTL
====================

FP16_VEC_REDUCE -- requirements
Module: fp16_vec_reduce

Interface
REQ-001 SHALL have parameter ADD_LAT, default 1, meaning the external adder latency in clocks (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the element-count width.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port s_valid, input, 1, meaning the input element is valid.
REQ-006 SHALL have port s_ready, output, 1, meaning the block accepts an element this cycle.
REQ-007 SHALL have port s_data, input, 16, the fp16 input element.
REQ-008 SHALL have port s_last, input, 1, meaning the element is the final one of its vector.
REQ-009 SHALL have port add_a, output, 16, the adder operand A (the current element).
REQ-010 SHALL have port add_b, output, 16, the adder operand B (the running accumulator).
REQ-011 SHALL have port add_res, input, 16, the adder result.
REQ-012 SHALL have port m_valid, output, 1, meaning the vector sum is available.
REQ-013 SHALL have port m_ready, input, 1, meaning downstream accepts the sum.
REQ-014 SHALL have port m_sum, output, 16, the fp16 vector sum.
REQ-015 SHALL have port m_count, output, CNT_W, the number of elements summed (saturating).
REQ-016 SHALL have port busy, output, 1, asserted when state is not ACCEPT or count != 0.

Function
REQ-017 SHALL implement FSM states ACCEPT, WAIT, OUT; reset state ACCEPT.
REQ-018 SHALL drive s_ready=1 only in ACCEPT, decoded from state only, with no combinational dependence on s_valid.
REQ-019 SHALL, on s_valid&&s_ready:
- capture s_data into op register
- capture s_last into last flag
- increment count, saturating at all-ones
- load wait counter with ADD_LAT
- enter WAIT
REQ-020 SHALL drive add_a=op and add_b=acc throughout WAIT, held stable for all ADD_LAT+1 WAIT cycles, and add_a=add_b=16'h0000 in other states.
REQ-021 SHALL treat add_res as valid ADD_LAT cycles after the operands are first presented.
REQ-022 SHALL, in WAIT, decrement the wait counter each cycle; in the cycle where the counter is 0:
- acc<=add_res
- next state OUT if last flag set, else ACCEPT
REQ-023 SHALL give a per-element throughput of one element per ADD_LAT+2 cycles.
REQ-024 SHALL, in OUT, drive m_valid=1, m_sum=acc, m_count=count, all held stable until m_ready.
REQ-025 SHALL, on m_valid&&m_ready, set acc<=16'h0000, count<=0, last flag<=0, and enter ACCEPT; the next vector may be accepted in the following cycle.
REQ-026 SHALL perform no fp arithmetic internally: NaN/inf/zero/rounding behaviour is wholly that of the attached adder, and acc is not modified beyond capture of add_res.
REQ-027 SHALL treat every vector as at least one element; s_last on the first element yields a one-element sum (element + 0x0000).
REQ-028 SHALL ignore s_valid, s_data and s_last outside ACCEPT.
REQ-029 SHALL ignore m_ready outside OUT.

Reset
REQ-030 SHALL, on rst_n low, reset immediately and asynchronously at any point, including mid-WAIT or mid-OUT:
- state ACCEPT
- acc=16'h0000, op=16'h0000, count=0, wait counter=0, last flag=0
- s_ready=1 after release, m_valid=0, m_sum=0, m_count=0, busy=0
- add_a=add_b=0
REQ-031 SHALL discard any in-flight partial sum at reset; the first vector after reset release sums from +0.

Verification
REQ-032 SHALL verify: ADD_LAT=1, elements 0x3C00, 0x4000, 0x4200(last) accepted at cycles t, t+3, t+6 -> m_valid rises at t+9 with m_sum=0x4600, m_count=3.
REQ-033 SHALL verify: single element 0xC500 with s_last -> m_sum=0xC500, m_count=1, m_valid at t+3.
REQ-034 SHALL verify: m_ready held 0 for 5 cycles in OUT -> m_valid, m_sum and m_count stable, s_ready=0, busy=1; the cycle after m_ready=1, s_ready=1.
REQ-035 SHALL verify: CNT_W=2, five elements of 0x3C00 -> m_sum=0x4500, m_count=3 (saturated).
REQ-036 SHALL verify: ADD_LAT=3, handshake at t -> add_a/add_b stable over t+1..t+4, acc captured at end of t+4, s_ready=1 at t+5.
REQ-037 SHALL verify: rst_n pulsed low during WAIT of the second element -> all outputs at reset values; a following vector 0x4000(last) gives m_sum=0x4000, m_count=1.

Source files
------------

// File: rtl/fp16_vec_reduce.sv
// rtl/fp16_vec_reduce.sv - fp16 vector sum reducer driving an external pipelined adder
//
// Accepts a stream of fp16 elements (s_valid/s_ready/s_data/s_last), folds each
// one into a running accumulator through an external adder with ADD_LAT clocks
// of latency, and presents the vector sum once the element flagged s_last has
// been folded in.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   s_valid/s_ready element handshake; s_ready decoded from state only
//   s_data, s_last  fp16 element and end-of-vector marker
//   add_a, add_b    adder operands (element, accumulator); zero outside WAIT
//   add_res         adder result, sampled ADD_LAT cycles after operands appear
//   m_valid/m_ready sum handshake
//   m_sum, m_count  vector sum and saturating element count
//   busy            state is not ACCEPT, or a vector is partially summed

module fp16_vec_reduce #(
   parameter int ADD_LAT = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [15:0]      s_data,
   input  logic             s_last,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   input  logic [15:0]      add_res,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      m_sum,
   output logic [CNT_W-1:0] m_count,
   output logic             busy
);

   typedef enum logic [1:0] {ACCEPT, WAIT, OUT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [15:0]      acc;
   logic [15:0]      op;
   logic [CNT_W-1:0] count;
   logic [2:0]       wait_cnt;
   logic             last_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCEPT;
         acc       <= 16'h0000;
         op        <= 16'h0000;
         count     <= '0;
         wait_cnt  <= 3'd0;
         last_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ACCEPT: begin
               if (s_valid) begin
                  op        <= s_data;
                  last_flag <= s_last;
                  if (count != {CNT_W{1'b1}})
                     count <= count + CNT_W'(1);
                  wait_cnt  <= 3'(ADD_LAT);
               end
            end
            WAIT: begin
               // Operands went out on the first WAIT cycle, so the adder result
               // is valid exactly when the counter has run down to zero.
               if (wait_cnt == 3'd0)
                  acc <= add_res;
               else
                  wait_cnt <= wait_cnt - 3'd1;
            end
            OUT: begin
               if (m_ready) begin
                  acc       <= 16'h0000;
                  count     <= '0;
                  last_flag <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      add_a     = 16'h0000;
      add_b     = 16'h0000;
      m_valid   = 1'b0;
      m_sum     = 16'h0000;
      m_count   = '0;
      case (state)
         ACCEPT: begin
            s_ready = 1'b1;
            if (s_valid)
               state_nxt = WAIT;
         end
         WAIT: begin
            add_a = op;
            add_b = acc;
            if (wait_cnt == 3'd0)
               state_nxt = last_flag ? OUT : ACCEPT;
         end
         OUT: begin
            m_valid = 1'b1;
            m_sum   = acc;
            m_count = count;
            if (m_ready)
               state_nxt = ACCEPT;
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   assign busy = (state != ACCEPT) || (count != '0);

endmodule
